// File: rtl/image_sys_sequencer.sv
// Job sequencer and data-RAM owner for the image-processing core.
// Loads the image into RAM, releases the processor until End_of_process,
// then streams the result region out through a valid/ready port.
module image_sys_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int LOAD_BASE = 0,
  parameter int IMG_SIZE  = 4096,
  parameter int OUT_BASE  = 4096,
  parameter int OUT_SIZE  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              proc_rst_n,
  input  logic              proc_ram_en,
  input  logic              proc_m_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_dout,
  input  logic              proc_end,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done
);

  // DUMP is split into read issue, capture of the synchronous read data,
  // and a hold state that waits for the sink.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_CAP,
    S_DUMP_HOLD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A  = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] IMG_LAST    = ADDR_W'(IMG_SIZE - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST    = ADDR_W'(OUT_SIZE - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] lcnt;
  logic [ADDR_W-1:0] dcnt;
  logic              load_fire;
  logic              dump_accept;

  assign load_fire   = (state == S_LOAD) && load_valid;
  assign dump_accept = (state == S_DUMP_HOLD) && dump_ready;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  // State register; processor release is registered off the next state so
  // it rises on the first RUN cycle and falls on the first cycle after RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      proc_rst_n <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, so ordering inside the block does not matter.
      state      <= state_next;
      proc_rst_n <= (state_next == S_RUN);
    end
  end

  // Next-state logic and RAM port mux; one owner of the RAM per state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    load_ready = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = LOAD_BASE_A + lcnt;
          ram_din  = load_data;
          if (lcnt == IMG_LAST) state_next = S_RUN;
        end
      end
      S_RUN: begin
        ram_en   = proc_ram_en;
        ram_we   = proc_m_write && proc_ram_en;
        ram_addr = proc_addr;
        ram_din  = proc_dout;
        if (proc_end) state_next = S_DUMP_RD;
      end
      S_DUMP_RD: begin
        ram_en     = 1'b1;
        ram_addr   = OUT_BASE_A + dcnt;
        state_next = S_DUMP_CAP;
      end
      S_DUMP_CAP: begin
        state_next = S_DUMP_HOLD;
      end
      S_DUMP_HOLD: begin
        if (dump_ready) state_next = (dcnt == OUT_LAST) ? S_DONE : S_DUMP_RD;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Load word counter: advances per transfer, clears after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt <= '0;
    end else if (load_fire) begin
      lcnt <= (lcnt == IMG_LAST) ? '0 : lcnt + ADDR_W'(1);
    end
  end

  // Dump word counter: advances per accepted word, clears after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
    end else if (dump_accept) begin
      dcnt <= (dcnt == OUT_LAST) ? '0 : dcnt + ADDR_W'(1);
    end
  end

  // Output word register: captured once per RAM read, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_valid <= 1'b0;
      dump_data  <= '0;
    end else if (state == S_DUMP_CAP) begin
      dump_valid <= 1'b1;
      dump_data  <= ram_dout;
    end else if (dump_accept) begin
      dump_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_image_sys_sequencer.sv
// Self-checking bench for image_sys_sequencer: three directed jobs against a
// behavioural RAM and a transaction-level expectation model.
module tb_image_sys_sequencer;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int LOAD_BASE = 0;
  localparam int IMG_SIZE  = 4;
  localparam int OUT_BASE  = 4096;
  localparam int OUT_SIZE  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              proc_rst_n;
  logic              proc_ram_en;
  logic              proc_m_write;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_dout;
  logic              proc_end;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic              dump_ready;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  image_sys_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_BASE(LOAD_BASE),
    .IMG_SIZE(IMG_SIZE), .OUT_BASE(OUT_BASE), .OUT_SIZE(OUT_SIZE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .proc_rst_n(proc_rst_n), .proc_ram_en(proc_ram_en), .proc_m_write(proc_m_write),
    .proc_addr(proc_addr), .proc_dout(proc_dout), .proc_end(proc_end),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .dump_valid(dump_valid), .dump_data(dump_data),
    .dump_ready(dump_ready), .busy(busy), .done(done)
  );

  // Synchronous single-port RAM with one-cycle read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  // Expectation model: RAM contents as the job rules imply, expected write
  // transactions in order, and expected dump words in order.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [DATA_W-1:0] model_mem [int];
  wr_t               exp_wr [$];
  logic [DATA_W-1:0] exp_dump [$];
  logic [DATA_W-1:0] dump_log [$];
  int                n_checks = 0;
  int                n_pass = 0;
  int                rd_count = 0;
  int                rd_start = 0;
  bit                prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  logic [DATA_W-1:0] w1 [IMG_SIZE];
  logic [DATA_W-1:0] w2 [IMG_SIZE];
  logic [DATA_W-1:0] w3 [IMG_SIZE];

  function automatic logic [DATA_W-1:0] model_rd(input int a);
    return model_mem.exists(a) ? model_mem[a] : '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison of RAM traffic and dump handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) check("we_implies_en", 32'(ram_en), 32'd1);
      if (ram_en && ram_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_ram_write", 32'(ram_we), 32'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("ram_write_addr", 32'(ram_addr), 32'(e.addr));
          check("ram_write_data", 32'(ram_din), 32'(e.data));
        end
      end
      if (ram_en && !ram_we) rd_count++;
      if (prev_hold) begin
        check("hold_dump_valid", 32'(dump_valid), 32'd1);
        check("hold_dump_data", 32'(dump_data), 32'(prev_data));
      end
      if (dump_valid && dump_ready) begin
        dump_log.push_back(dump_data);
        if (exp_dump.size() == 0) begin
          check("unexpected_dump_word", 32'(dump_valid), 32'd0);
        end else begin
          check("dump_word", 32'(dump_data), 32'(exp_dump.pop_front()));
        end
      end
      prev_hold = dump_valid && !dump_ready;
      prev_data = dump_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input bit hold);
    start = 1'b1;
    tick();
    start = hold;
  endtask

  // Feed IMG_SIZE words, optionally with an idle cycle after each transfer.
  task automatic load_words(input logic [DATA_W-1:0] w [IMG_SIZE], input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < IMG_SIZE && guard < 50) begin
      guard++;
      if (gaps && (guard % 2 == 0)) begin
        load_valid = 1'b0;
        load_data  = 16'hFFFF;
        @(negedge clk);
        check("load_gap_ram_en", 32'(ram_en), 32'd0);
        check("load_gap_ready", 32'(load_ready), 32'd1);
      end else begin
        load_valid = 1'b1;
        load_data  = w[i];
        exp_wr.push_back({ADDR_W'(LOAD_BASE + i), w[i]});
        model_mem[LOAD_BASE + i] = w[i];
        @(negedge clk);
        check("load_ready", 32'(load_ready), 32'd1);
        check("load_proc_held", 32'(proc_rst_n), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        i++;
      end
      tick();
    end
    load_valid   = 1'b0;
    start        = 1'b0;
    proc_end     = 1'b0;
    proc_ram_en  = 1'b0;
    proc_m_write = 1'b0;
    @(negedge clk);
    check("run_proc_released", 32'(proc_rst_n), 32'd1);
    check("run_load_ready", 32'(load_ready), 32'd0);
    tick();
  endtask

  // Processor activity in RUN: a disabled write, one real write, then End.
  task automatic run_proc(input int addr, input logic [DATA_W-1:0] data, input bit start_noise);
    start        = start_noise;
    proc_ram_en  = 1'b0;
    proc_m_write = 1'b1;
    proc_addr    = 16'h0005;
    proc_dout    = 16'h5555;
    @(negedge clk);
    check("run_disabled_en", 32'(ram_en), 32'd0);
    check("run_disabled_we", 32'(ram_we), 32'd0);
    tick();
    start        = 1'b0;
    proc_ram_en  = 1'b1;
    proc_m_write = 1'b1;
    proc_addr    = ADDR_W'(addr);
    proc_dout    = data;
    exp_wr.push_back({ADDR_W'(addr), data});
    model_mem[addr] = data;
    @(negedge clk);
    check("run_still_released", 32'(proc_rst_n), 32'd1);
    check("run_passthru_addr", 32'(ram_addr), 32'(addr));
    tick();
    proc_ram_en  = 1'b0;
    proc_m_write = 1'b0;
    proc_end     = 1'b1;
    @(negedge clk);
    rd_start = rd_count;
    check("run_end_cycle_released", 32'(proc_rst_n), 32'd1);
    tick();
    proc_end = 1'b0;
    @(negedge clk);
    check("dump_proc_held", 32'(proc_rst_n), 32'd0);
    check("dump_rd_en", 32'(ram_en), 32'd1);
    check("dump_rd_we", 32'(ram_we), 32'd0);
    check("dump_rd_addr", 32'(ram_addr), 32'(OUT_BASE));
  endtask

  // Stream out all result words; optionally stall the first one.
  task automatic dump_all(input bit hold_first, input bit toggle_ready,
                          input logic [DATA_W-1:0] first_word);
    bit got;
    for (int k = 0; k < OUT_SIZE; k++) exp_dump.push_back(model_rd(OUT_BASE + k));
    tick();
    if (hold_first) begin
      dump_ready = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (dump_valid) got = 1'b1;
        else tick();
      end
      check("dump_first_valid", 32'(dump_valid), 32'd1);
      check("dump_first_word", 32'(dump_data), 32'(first_word));
      for (int c = 0; c < 5; c++) begin
        tick();
        @(negedge clk);
        check("dump_stall_valid", 32'(dump_valid), 32'd1);
      end
      tick();
    end
    got = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      dump_ready = toggle_ready ? (c % 3 != 2) : 1'b1;
      @(negedge clk);
      if (done) got = 1'b1;
      else tick();
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("dump_ram_reads", 32'(rd_count - rd_start), 32'(OUT_SIZE));
    check("dump_all_consumed", 32'(exp_dump.size()), 32'd0);
    tick();
    dump_ready = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_proc_rst_n"}, 32'(proc_rst_n), 32'd0);
    check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_din"}, 32'(ram_din), 32'd0);
    check({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
    check({tag, "_dump_data"}, 32'(dump_data), 32'd0);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    w1 = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    w2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    w3 = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
    for (int k = 0; k < OUT_SIZE; k++) begin
      mem[OUT_BASE + k]        <= 16'hD000 + 16'(k);
      model_mem[OUT_BASE + k]  = 16'hD000 + 16'(k);
    end
    // NOTE: inputs change #1 after the rising edge and outputs are sampled on
    // the falling edge, so the DUT never sees an input race its clock.
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0;
    proc_ram_en = 1'b0; proc_m_write = 1'b0; proc_addr = '0; proc_dout = '0;
    proc_end = 1'b0; dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Job 1: back-to-back load, start ignored in RUN, stalled first dump word.
    kick(1'b0);
    load_words(w1, 1'b0);
    run_proc(4096, 16'hBEEF, 1'b1);
    dump_all(1'b1, 1'b0, 16'hBEEF);

    // Job 2: gapped load with start and proc_end noise, reset mid-DUMP.
    proc_end = 1'b1; proc_ram_en = 1'b1; proc_m_write = 1'b1;
    proc_addr = 16'h0100; proc_dout = 16'hDEAD;
    tick();
    kick(1'b1);
    load_words(w2, 1'b1);
    run_proc(4097, 16'hCAFE, 1'b0);
    exp_dump.push_back(model_rd(OUT_BASE));
    tick();
    dump_ready = 1'b1;
    tick();
    tick();
    check("mid_dump_second_rd_en", 32'(ram_en), 32'd1);
    check("mid_dump_second_rd_addr", 32'(ram_addr), 32'(OUT_BASE + 1));
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("mid_dump_first_consumed", 32'(exp_dump.size()), 32'd0);
    exp_dump.delete();
    dump_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Job 3: fresh full job, sink toggling ready.
    kick(1'b0);
    load_words(w3, 1'b0);
    run_proc(4099, 16'h1234, 1'b0);
    dump_all(1'b0, 1'b1, 16'h0000);
    check("job3_word0_literal", 32'(dump_log[dump_log.size() - 4]), 32'h0000BEEF);
    check("job3_word1_literal", 32'(dump_log[dump_log.size() - 3]), 32'h0000CAFE);
    check("job3_word2_literal", 32'(dump_log[dump_log.size() - 2]), 32'h0000D002);
    check("job3_word3_literal", 32'(dump_log[dump_log.size() - 1]), 32'h00001234);
    check("no_pending_writes", 32'(exp_wr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
